store_queue: RTL and testbench
==============================

Name: store_queue

Overview:
- Parametrised store path that replaces the purely combinational byte-enable stage.
- Accepts store requests (address, store type, 32-bit register data) from the MEM stage and checks alignment.
- Generates lane enables and lane-positioned data for a DATA_W-wide data bus, buffers them in a DEPTH-entry FIFO, and drains to data memory over a valid/ready handshake.
- Sits between the MEM-stage pipeline register and the data-memory / bus bridge.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, memory data width in bits; power of two, at least 32; LANES = DATA_W/8
DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous, active-low reset (reset==0 clears the block at the clk edge)
In_Valid  input  1  store request present
In_Ready  output  1  block can accept a request this cycle
In_Addr  input  ADDR_W  byte address
In_StType  input  `StType_WIDE  store type: `SW / `SH / `SB / `NOSAVE
In_Data  input  32  register data; low 8/16/32 bits used
Flush  input  1  discard all buffered, not-yet-accepted stores
Exc_AdES  output  1  one-cycle pulse: the previous accepted request was misaligned
Mem_Valid  output  1  head entry valid
Mem_Ready  input  1  memory accepts the head entry
Mem_Addr  output  ADDR_W  In_Addr with low log2(LANES) bits cleared
Mem_ByteEn  output  LANES  lane enables
Mem_WrData  output  DATA_W  lane-positioned data; disabled lanes are 0
Empty  output  1  no buffered entries
Count  output  log2(DEPTH)+1  number of buffered entries

Behaviour:
- Reset (reset==0 at edge): Count=0, read/write pointers=0, Exc_AdES=0. Mem_Valid=0 and Empty=1 follow from Count=0. Reset overrides Flush and all handshakes in the same cycle.
- Handshake definitions:
  - In handshake = In_Valid & In_Ready.
  - In_Ready = (Count<DEPTH) & ~Flush.
  - There is no bypass: when full, a same-cycle drain does not raise In_Ready.
- Lane generation (combinational, at accept):
  - off = In_Addr[log2(LANES)-1:0].
  - SB enables lane off, with In_Data[7:0] in that lane.
  - SH enables lanes off and off+1, with In_Data[15:0].
  - SW enables lanes off..off+3, with In_Data[31:0].
  - Data is little-endian within lanes; all other lanes are 0.
- Alignment:
  - SH with In_Addr[0]!=0, or SW with In_Addr[1:0]!=0, is accepted but not enqueued.
  - Exc_AdES=1 for exactly the next cycle.
  - SB is never misaligned.
- NOSAVE, or any undefined StType, is accepted and dropped: no enqueue, no exception.
- Enqueue latency: an entry written at edge N shows Mem_Valid=1 from cycle N+1.
- Drain interface:
  - Mem_Valid = ~Empty.
  - Mem_Addr/Mem_ByteEn/Mem_WrData show the head entry and are forced to 0 when Empty.
  - Head outputs stay stable while Mem_Valid & ~Mem_Ready.
  - Mem_Valid & Mem_Ready pops the head at that edge.
- Simultaneous enqueue and pop when 0<Count<DEPTH: Count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count distinguishes full from empty.
- Flush:
  - Count=0 and both pointers=0 at the edge.
  - A same-cycle Mem handshake is treated as completed; memory has taken that beat.
  - No enqueue can occur, since In_Ready=0.
  - Exc_AdES already scheduled still pulses.
- Order guarantee: stores reach memory in acceptance order. Nothing is reordered or merged.

Decomposition:
- Shared package (macro.v):
  - `StType_WIDE and the `SW/`SH/`SB/`NOSAVE codes.
  - The existing `Save_* enable constants, which are used only by the DATA_W=32 self-check.
- Sub-module store_lane_gen (combinational): StType, offset and data in; ByteEn, WrData and misalign flag out, for LANES lanes.
- FIFO storage and control stay in store_queue.

Test Plan:
- Reset held low 2 cycles with In_Valid=1 -> Count=0, Mem_Valid=0, Exc_AdES=0, Mem_* all 0. Release -> accept on next cycle.
- DATA_W=32: SB 0x1003 data 0xAB, then SH 0x1002 data 0x1234, then SW 0x1000 data 0xDEADBEEF, Mem_Ready=1 -> three beats in order:
  - beat 1: Addr 0x1000, ByteEn 4'b1000, WrData 0xAB000000
  - beat 2: ByteEn 4'b1100, WrData 0x12340000
  - beat 3: ByteEn 4'b1111, WrData 0xDEADBEEF
- DATA_W=64: SH 0x2006 data 0x5A5A -> Mem_Addr 0x2000, ByteEn 8'hC0, WrData 0x5A5A000000000000.
- SW 0x1001, then SH 0x1003 -> no enqueue, Exc_AdES pulses one cycle after each accept, Count stays 0. NOSAVE -> no pulse.
- DEPTH=4, Mem_Ready=0, five requests -> In_Ready drops after 4, Count=4, head held stable. Then Mem_Ready=1 with In_Valid=1 -> one pop and no same-cycle accept, then accept next cycle; pointers wrap and order is preserved.
- Count=3, Flush=1 together with Mem_Valid&Mem_Ready -> head beat counted as delivered, Count=0 next cycle, In_Ready=0 during the Flush cycle.

Source files
------------

// File: rtl/store_queue_pkg.sv
// rtl/store_queue_pkg.sv - store type codes and lane-enable constants for the store path
//
// Purpose: shared definitions for store_queue and store_lane_gen.
//   ST_W / ST_*  : store-type field width and codes carried from the MEM stage.
//   SAVE_*       : 4-lane byte-enable patterns of a 32-bit data bus, kept for
//                  checking the DATA_W=32 configuration.
package store_queue_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_NOSAVE = 3'b000;
  localparam logic [ST_W-1:0] ST_SW     = 3'b001;
  localparam logic [ST_W-1:0] ST_SH     = 3'b010;
  localparam logic [ST_W-1:0] ST_SB     = 3'b011;

  localparam logic [3:0] SAVE_NONE = 4'b0000;
  localparam logic [3:0] SAVE_W    = 4'b1111;
  localparam logic [3:0] SAVE_H0   = 4'b0011;
  localparam logic [3:0] SAVE_H2   = 4'b1100;
  localparam logic [3:0] SAVE_B0   = 4'b0001;
  localparam logic [3:0] SAVE_B1   = 4'b0010;
  localparam logic [3:0] SAVE_B2   = 4'b0100;
  localparam logic [3:0] SAVE_B3   = 4'b1000;

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - combinational byte-lane enable and data positioning for one store
//
// Purpose: maps a store (type, byte offset within the bus word, register data)
// onto LANES byte lanes of a DATA_W-wide bus.
// Ports:
//   st_type   in  store type code
//   off       in  byte offset of the store inside the bus word
//   data      in  32-bit register data, low 8/16/32 bits used
//   byte_en   out lane enables
//   wr_data   out lane-positioned data, disabled lanes 0
//   is_store  out st_type is SB/SH/SW
//   misalign  out SH on an odd offset or SW on a non-word offset
module store_lane_gen
  import store_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = DATA_W / 8,
  parameter int OFF_W  = $clog2(LANES)
) (
  input  logic [ST_W-1:0]   st_type,
  input  logic [OFF_W-1:0]  off,
  input  logic [31:0]       data,
  output logic [LANES-1:0]  byte_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              is_store,
  output logic              misalign
);

  logic [LANES-1:0]  base_en;
  logic [DATA_W-1:0] base_data;

  always_comb begin
    base_en   = '0;
    base_data = '0;
    is_store  = 1'b0;
    misalign  = 1'b0;
    unique case (st_type)
      ST_SB: begin
        is_store       = 1'b1;
        base_en[0]     = 1'b1;
        base_data[7:0] = data[7:0];
      end
      ST_SH: begin
        is_store        = 1'b1;
        base_en[1:0]    = 2'b11;
        base_data[15:0] = data[15:0];
        misalign        = off[0];
      end
      ST_SW: begin
        is_store        = 1'b1;
        base_en[3:0]    = 4'hF;
        base_data[31:0] = data;
        misalign        = |off[1:0];
      end
      default: ;
    endcase
    // Aligned stores never cross the bus word, so a plain shift places them.
    // Misaligned ones are discarded by the caller, so their shifted value is irrelevant.
    byte_en = base_en << off;
    wr_data = base_data << {off, 3'b000};
  end

endmodule

// File: rtl/store_queue.sv
// rtl/store_queue.sv - aligned store buffer between the MEM stage and data memory
//
// Purpose: accepts store requests, flags misaligned ones, converts the rest to
// lane enables/data and holds them in a DEPTH-entry FIFO drained over valid/ready.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   In_Valid/In_Ready     request handshake from the MEM stage
//   In_Addr/In_StType/In_Data  store request
//   Flush                 drop every buffered store, block new requests
//   Exc_AdES              one-cycle pulse after a misaligned request is accepted
//   Mem_Valid/Mem_Ready   drain handshake toward data memory
//   Mem_Addr/Mem_ByteEn/Mem_WrData  head entry, 0 when empty
//   Empty/Count           occupancy
module store_queue
  import store_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int LANES = DATA_W / 8,
  localparam int OFF_W = $clog2(LANES),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [ADDR_W-1:0] In_Addr,
  input  logic [ST_W-1:0]   In_StType,
  input  logic [31:0]       In_Data,
  input  logic              Flush,
  output logic              Exc_AdES,
  output logic              Mem_Valid,
  input  logic              Mem_Ready,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [LANES-1:0]  Mem_ByteEn,
  output logic [DATA_W-1:0] Mem_WrData,
  output logic              Empty,
  output logic [CNT_W-1:0]  Count
);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              exc_q, exc_d;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [LANES-1:0]  ben_q  [DEPTH];
  logic [LANES-1:0]  ben_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [LANES-1:0]  gen_en;
  logic [DATA_W-1:0] gen_data;
  logic              gen_is_store;
  logic              gen_misalign;
  logic [ADDR_W-1:0] word_addr;

  logic accept;
  logic push;
  logic pop;
  logic empty;

  store_lane_gen #(
    .DATA_W (DATA_W)
  ) u_lane_gen (
    .st_type  (In_StType),
    .off      (In_Addr[OFF_W-1:0]),
    .data     (In_Data),
    .byte_en  (gen_en),
    .wr_data  (gen_data),
    .is_store (gen_is_store),
    .misalign (gen_misalign)
  );

  always_comb begin
    word_addr             = In_Addr;
    word_addr[OFF_W-1:0]  = '0;
  end

  assign empty = (count_q == '0);
  // No bypass: a full queue stays closed even if the head leaves this cycle.
  assign In_Ready = (count_q < CNT_W'(DEPTH)) & ~Flush;
  assign accept   = In_Valid & In_Ready;
  // NOSAVE, undefined codes and misaligned stores are accepted but never buffered.
  assign push     = accept & gen_is_store & ~gen_misalign;
  assign pop      = ~empty & Mem_Ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Flush cannot cancel a pulse already registered; it only blocks new requests.
    exc_d    = accept & gen_is_store & gen_misalign;

    if (Flush) begin
      // A beat handed over during Flush is treated as delivered; nothing to undo.
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    addr_d = addr_q;
    ben_d  = ben_q;
    data_d = data_q;
    if (push) begin
      addr_d[wr_ptr_q] = word_addr;
      ben_d[wr_ptr_q]  = gen_en;
      data_d[wr_ptr_q] = gen_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      exc_q    <= exc_d;
    end
  end

  // Payload storage needs no reset: it is only observed through the empty gate.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    ben_q  <= ben_d;
    data_q <= data_d;
  end

  assign Exc_AdES   = exc_q;
  assign Empty      = empty;
  assign Count      = count_q;
  assign Mem_Valid  = ~empty;
  assign Mem_Addr   = empty ? '0 : addr_q[rd_ptr_q];
  assign Mem_ByteEn = empty ? '0 : ben_q[rd_ptr_q];
  assign Mem_WrData = empty ? '0 : data_q[rd_ptr_q];

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - directed self-checking bench for store_queue
module tb_store_queue;
  import store_queue_pkg::*;

  logic        clk;
  logic        reset;
  logic        In_Valid, In_Ready, Flush, Exc_AdES;
  logic [31:0] In_Addr, In_Data;
  logic [2:0]  In_StType;
  logic        Mem_Valid, Mem_Ready, Empty;
  logic [31:0] Mem_Addr, Mem_WrData;
  logic [3:0]  Mem_ByteEn;
  logic [2:0]  Count;

  logic        v64, rdy64, flush64, exc64, mv64, mr64, empty64;
  logic [31:0] addr64, data64, maddr64;
  logic [2:0]  st64, count64;
  logic [7:0]  ben64;
  logic [63:0] mdata64;

  int tests_run    = 0;
  int tests_failed = 0;

  store_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Addr(In_Addr),
    .In_StType(In_StType), .In_Data(In_Data), .Flush(Flush),
    .Exc_AdES(Exc_AdES), .Mem_Valid(Mem_Valid), .Mem_Ready(Mem_Ready),
    .Mem_Addr(Mem_Addr), .Mem_ByteEn(Mem_ByteEn), .Mem_WrData(Mem_WrData),
    .Empty(Empty), .Count(Count)
  );

  store_queue #(.ADDR_W(32), .DATA_W(64), .DEPTH(4)) u_dut64 (
    .clk(clk), .reset(reset),
    .In_Valid(v64), .In_Ready(rdy64), .In_Addr(addr64),
    .In_StType(st64), .In_Data(data64), .Flush(flush64),
    .Exc_AdES(exc64), .Mem_Valid(mv64), .Mem_Ready(mr64),
    .Mem_Addr(maddr64), .Mem_ByteEn(ben64), .Mem_WrData(mdata64),
    .Empty(empty64), .Count(count64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] st, input logic [31:0] a, input logic [31:0] d);
    In_Valid  = v;
    In_StType = st;
    In_Addr   = a;
    In_Data   = d;
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    check({tag, "_valid"}, Mem_Valid, 1'b1);
    check({tag, "_addr"},  Mem_Addr,  a);
    check({tag, "_ben"},   Mem_ByteEn, be);
    check({tag, "_data"},  Mem_WrData, d);
  endtask

  initial begin
    reset = 1'b0; Flush = 1'b0; Mem_Ready = 1'b0;
    drive(1'b1, ST_SW, 32'h1000, 32'h1122_3344);
    v64 = 1'b0; st64 = ST_NOSAVE; addr64 = '0; data64 = '0; flush64 = 1'b0; mr64 = 1'b0;

    // Reset held two cycles while a request is presented.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_count", Count, 3'd0);
      check("rst_mvalid", Mem_Valid, 1'b0);
      check("rst_exc", Exc_AdES, 1'b0);
      check("rst_empty", Empty, 1'b1);
      check("rst_maddr", Mem_Addr, 32'h0);
      check("rst_mben", Mem_ByteEn, 4'h0);
      check("rst_mdata", Mem_WrData, 32'h0);
    end
    reset = 1'b1;
    step();
    drive(1'b0, ST_NOSAVE, 32'h0, 32'h0);
    check("first_count", Count, 3'd1);
    check_head("first", 32'h1000, SAVE_W, 32'h1122_3344);
    Mem_Ready = 1'b1;
    step();
    check("first_drained", Empty, 1'b1);

    // Three stores streamed with memory always ready.
    drive(1'b1, ST_SB, 32'h1003, 32'h0000_00AB);
    step();
    check_head("beat1", 32'h1000, SAVE_B3, 32'hAB00_0000);
    drive(1'b1, ST_SH, 32'h1002, 32'h0000_1234);
    step();
    check("beat2_count", Count, 3'd1);
    check_head("beat2", 32'h1000, SAVE_H2, 32'h1234_0000);
    drive(1'b1, ST_SW, 32'h1000, 32'hDEAD_BEEF);
    step();
    check_head("beat3", 32'h1000, SAVE_W, 32'hDEAD_BEEF);
    drive(1'b0, ST_NOSAVE, 32'h0, 32'h0);
    step();
    check("stream_empty", Count, 3'd0);

    // Misaligned and dropped requests.
    Mem_Ready = 1'b0;
    drive(1'b1, ST_SW, 32'h1001, 32'h1);
    step();
    drive(1'b0, ST_NOSAVE, 32'h0, 32'h0);
    check("sw_mis_exc", Exc_AdES, 1'b1);
    check("sw_mis_count", Count, 3'd0);
    step();
    check("sw_mis_exc_end", Exc_AdES, 1'b0);
    drive(1'b1, ST_SH, 32'h1003, 32'h2);
    step();
    drive(1'b0, ST_NOSAVE, 32'h0, 32'h0);
    check("sh_mis_exc", Exc_AdES, 1'b1);
    check("sh_mis_count", Count, 3'd0);
    drive(1'b1, ST_NOSAVE, 32'h1001, 32'h3);
    step();
    check("nosave_exc", Exc_AdES, 1'b0);
    check("nosave_count", Count, 3'd0);
    drive(1'b1, 3'b111, 32'h1003, 32'h4);
    step();
    check("undef_exc", Exc_AdES, 1'b0);
    check("undef_count", Count, 3'd0);
    drive(1'b1, ST_SB, 32'h1001, 32'h0000_00C3);
    step();
    drive(1'b0, ST_NOSAVE, 32'h0, 32'h0);
    check("sb_odd_exc", Exc_AdES, 1'b0);
    check_head("sb_odd", 32'h1000, SAVE_B1, 32'h0000_C300);
    Mem_Ready = 1'b1;
    step();
    Mem_Ready = 1'b0;
    check("sb_odd_drained", Count, 3'd0);

    // Fill to DEPTH with memory stalled; fifth request is refused.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ST_SW, 32'h3000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
      #1;
      check($sformatf("fill_ready%0d", i), In_Ready, (i < 4) ? 1'b1 : 1'b0);
      step();
    end
    check("full_count", Count, 3'd4);
    check_head("full_head", 32'h3000, SAVE_W, 32'hA000_0000);
    Mem_Ready = 1'b1;
    #1;
    check("full_no_bypass", In_Ready, 1'b0);
    step();
    check("pop_count", Count, 3'd3);
    check_head("pop1", 32'h3004, SAVE_W, 32'hA000_0001);
    check("reopen_ready", In_Ready, 1'b1);
    step();
    drive(1'b0, ST_NOSAVE, 32'h0, 32'h0);
    check("wrap_count", Count, 3'd3);
    check_head("pop2", 32'h3008, SAVE_W, 32'hA000_0002);
    step();
    check_head("pop3", 32'h300C, SAVE_W, 32'hA000_0003);
    step();
    check_head("pop4", 32'h3010, SAVE_W, 32'hA000_0004);
    check("pop4_count", Count, 3'd1);
    step();
    check("wrap_empty", Empty, 1'b1);

    // Flush with three buffered and a live drain beat.
    Mem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ST_SB, 32'h4000 + 32'(i), 32'(i + 1));
      step();
    end
    check("preflush_count", Count, 3'd3);
    drive(1'b1, ST_SW, 32'h5000, 32'h9999_9999);
    Flush = 1'b1;
    Mem_Ready = 1'b1;
    #1;
    check("flush_ready", In_Ready, 1'b0);
    check_head("flush_head", 32'h4000, SAVE_B0, 32'h0000_0001);
    step();
    Flush = 1'b0;
    drive(1'b0, ST_NOSAVE, 32'h0, 32'h0);
    check("flush_count", Count, 3'd0);
    check("flush_mvalid", Mem_Valid, 1'b0);

    // A misaligned pulse already scheduled survives a Flush.
    Mem_Ready = 1'b0;
    drive(1'b1, ST_SW, 32'h6002, 32'h0);
    step();
    drive(1'b0, ST_NOSAVE, 32'h0, 32'h0);
    Flush = 1'b1;
    #1;
    check("flush_exc", Exc_AdES, 1'b1);
    step();
    Flush = 1'b0;
    drive(1'b1, ST_SH, 32'h7000, 32'h0000_BEEF);
    step();
    drive(1'b0, ST_NOSAVE, 32'h0, 32'h0);
    check_head("post_flush", 32'h7000, SAVE_H0, 32'h0000_BEEF);

    // 64-bit bus instance.
    v64 = 1'b1; st64 = ST_SH; addr64 = 32'h2006; data64 = 32'h0000_5A5A;
    step();
    st64 = ST_SW; addr64 = 32'h2004; data64 = 32'hCAFE_F00D;
    check("w64_addr", maddr64, 32'h2000);
    check("w64_ben", ben64, 8'hC0);
    check("w64_data", mdata64, 64'h5A5A_0000_0000_0000);
    mr64 = 1'b1;
    step();
    v64 = 1'b0;
    check("w64_sw_ben", ben64, 8'hF0);
    check("w64_sw_data", mdata64, 64'hCAFE_F00D_0000_0000);
    step();
    check("w64_empty", empty64, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
